seq_alu: RTL and testbench

Parametrised multi-cycle ALU, successor to the single-cycle combinational ALU on the datapath bus. It accepts one-hot operation requests through a start/done handshake and computes single-cycle logic and arithmetic ops in one cycle. Signed multiply uses iterative radix-2 Booth; signed divide uses iterative restoring division. It sits between the Y/Z registers and the bus, drives the HI/LO-style double-width result, and flags divide-by-zero and illegal control words.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_iter_unit.sv | 126 ++++++++++++
 rtl/seq_alu.sv | 148 ++++++++++++++
 tb/tb_seq_alu.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Holds the op bit indices of the one-hot ctrl_signal, the FSM state encoding
// and a helper that checks whether a control word has exactly one bit set.
package alu_pkg;

   localparam int unsigned SIG_W = 12;

   localparam int unsigned OP_ADD = 0;
   localparam int unsigned OP_SUB = 1;
   localparam int unsigned OP_MUL = 2;
   localparam int unsigned OP_DIV = 3;
   localparam int unsigned OP_SHR = 4;
   localparam int unsigned OP_SHL = 5;
   localparam int unsigned OP_ROR = 6;
   localparam int unsigned OP_ROL = 7;
   localparam int unsigned OP_AND = 8;
   localparam int unsigned OP_OR  = 9;
   localparam int unsigned OP_NEG = 10;
   localparam int unsigned OP_NOT = 11;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StDone = 2'd2
   } state_t;

   // v & (v - 1) clears the lowest set bit; zero afterwards means at most one bit.
   function automatic logic is_one_hot(input logic [SIG_W-1:0] v);
      return (v != '0) && ((v & (v - SIG_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath shared by signed multiply (radix-2 Booth) and signed
// divide (restoring division on magnitudes plus a final sign correction).
// Ports:
//   clock, clear_n     clock and asynchronous active-low reset
//   load               capture operands/mode and preset the iteration counter
//   mode_div           at load: 1 = divide, 0 = multiply
//   step               advance one iteration (one cycle of CALC)
//   op_a, op_b         X (multiplicand / dividend), Y (multiplier / divisor)
//   ready              counter is 0: the current step is the final one
//   result             value valid when step && ready: product, or {rem, quo}
module alu_iter_unit #(
   parameter int unsigned BITS = 32
) (
   input  logic            clock,
   input  logic            clear_n,
   input  logic            load,
   input  logic            mode_div,
   input  logic            step,
   input  logic [BITS-1:0] op_a,
   input  logic [BITS-1:0] op_b,
   output logic            ready,
   output logic [2*BITS-1:0] result
);

   localparam int unsigned CntW = $clog2(BITS) + 1;

   // Multiply layout: {acc[BITS], multiplier[BITS], q_minus1}.
   // Divide layout:   {rem[BITS+1], quotient[BITS]}.
   logic [2*BITS:0] part_q, part_d;
   logic [BITS-1:0] mcand_q, mcand_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            div_q, div_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;

   logic [BITS-1:0]   acc;
   logic [BITS:0]     sum;
   logic [2*BITS:0]   mul_next;
   logic [2*BITS:0]   shifted;
   logic [BITS+1:0]   diff;
   logic [2*BITS:0]   div_next;
   logic [BITS-1:0]   quo_mag, rem_mag;
   logic [BITS-1:0]   a_mag, b_mag;

   always_comb begin
      acc = part_q[2*BITS:BITS+1];
      // One guard bit keeps acc +/- mcand exact even for the most negative mcand.
      unique case (part_q[1:0])
         2'b01:   sum = {acc[BITS-1], acc} + {mcand_q[BITS-1], mcand_q};
         2'b10:   sum = {acc[BITS-1], acc} - {mcand_q[BITS-1], mcand_q};
         default: sum = {acc[BITS-1], acc};
      endcase
      // Arithmetic right shift of the whole partial register.
      mul_next = {sum[BITS:1], sum[0], part_q[BITS:1]};

      shifted  = {part_q[2*BITS-1:0], 1'b0};
      diff     = {1'b0, shifted[2*BITS:BITS]} - {2'b00, mcand_q};
      div_next = diff[BITS+1] ? shifted : {diff[BITS:0], shifted[BITS-1:1], 1'b1};

      quo_mag = part_q[BITS-1:0];
      rem_mag = part_q[2*BITS-1:BITS];

      a_mag = op_a[BITS-1] ? -op_a : op_a;
      b_mag = op_b[BITS-1] ? -op_b : op_b;
   end

   assign ready  = (cnt_q == '0);
   assign result = div_q ? {(neg_rem_q ? -rem_mag : rem_mag),
                            (neg_quo_q ? -quo_mag : quo_mag)}
                         : mul_next[2*BITS:1];

   always_comb begin
      part_d    = part_q;
      mcand_d   = mcand_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      if (load) begin
         div_d = mode_div;
         if (mode_div) begin
            part_d    = {{(BITS+1){1'b0}}, a_mag};
            mcand_d   = b_mag;
            cnt_d     = CntW'(BITS);
            neg_quo_d = op_a[BITS-1] ^ op_b[BITS-1];
            neg_rem_d = op_a[BITS-1];
         end else begin
            part_d    = {{BITS{1'b0}}, op_b, 1'b0};
            mcand_d   = op_a;
            cnt_d     = CntW'(BITS - 1);
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
         end
      end else if (step) begin
         // Multiply steps on every cycle; divide spends its last cycle (count 0)
         // on sign correction, which is formed combinationally in result.
         if (!div_q) begin
            part_d = mul_next;
         end else if (cnt_q != '0) begin
            part_d = div_next;
         end
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         part_q    <= '0;
         mcand_q   <= '0;
         cnt_q     <= '0;
         div_q     <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         part_q    <= part_d;
         mcand_q   <= mcand_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with a start/done handshake.
// Ports:
//   clock, clear_n   clock and asynchronous active-low reset
//   start            request, sampled only in IDLE
//   ctrl_signal      one-hot op select (see alu_pkg OP_* indices)
//   X, Y             operands; Y[log2(BITS)-1:0] is the shift amount
//   busy             high while the op is being computed
//   done             one-cycle pulse, OpResult valid
//   OpResult         double-width result, held until replaced
//   div_zero, err    divide-by-zero / illegal-control flags, valid with done
module seq_alu
   import alu_pkg::*;
#(
   parameter int unsigned BITS      = 32,
   parameter int unsigned SIG_COUNT = 12
) (
   input  logic                 clock,
   input  logic                 clear_n,
   input  logic                 start,
   input  logic [SIG_COUNT-1:0] ctrl_signal,
   input  logic [BITS-1:0]      X,
   input  logic [BITS-1:0]      Y,
   output logic                 busy,
   output logic                 done,
   output logic [2*BITS-1:0]    OpResult,
   output logic                 div_zero,
   output logic                 err
);

   localparam int unsigned ShW = $clog2(BITS);

   state_t                state_q, state_d;
   logic [BITS-1:0]       x_q, y_q;
   logic [SIG_COUNT-1:0]  ctrl_q;
   logic [2*BITS-1:0]     res_q, res_d;
   logic                  div_zero_q, div_zero_d;
   logic                  err_q, err_d;

   logic                  accept;
   logic                  legal;
   logic [ShW-1:0]        shamt;
   logic [ShW:0]          shamt_inv;
   logic [BITS-1:0]       simple_res;
   logic                  iter_step;
   logic                  iter_ready;
   logic [2*BITS-1:0]     iter_result;

   assign accept = (state_q == StIdle) && start;
   assign legal  = is_one_hot(ctrl_q);
   assign shamt  = y_q[ShW-1:0];
   // BITS - shamt; equals BITS when shamt is 0, so the wrap-around term shifts out to 0.
   assign shamt_inv = (ShW+1)'(BITS) - {1'b0, shamt};

   alu_iter_unit #(
      .BITS (BITS)
   ) u_iter (
      .clock    (clock),
      .clear_n  (clear_n),
      .load     (accept),
      .mode_div (ctrl_signal[OP_DIV]),
      .step     (iter_step),
      .op_a     (X),
      .op_b     (Y),
      .ready    (iter_ready),
      .result   (iter_result)
   );

   always_comb begin
      simple_res = '0;
      if (ctrl_q[OP_ADD])      simple_res = x_q + y_q;
      else if (ctrl_q[OP_SUB]) simple_res = x_q - y_q;
      else if (ctrl_q[OP_SHR]) simple_res = x_q >> shamt;
      else if (ctrl_q[OP_SHL]) simple_res = x_q << shamt;
      else if (ctrl_q[OP_ROR]) simple_res = (x_q >> shamt) | (x_q << shamt_inv);
      else if (ctrl_q[OP_ROL]) simple_res = (x_q << shamt) | (x_q >> shamt_inv);
      else if (ctrl_q[OP_AND]) simple_res = x_q & y_q;
      else if (ctrl_q[OP_OR])  simple_res = x_q | y_q;
      else if (ctrl_q[OP_NEG]) simple_res = -x_q;
      else if (ctrl_q[OP_NOT]) simple_res = ~x_q;
   end

   always_comb begin
      state_d    = state_q;
      res_d      = res_q;
      div_zero_d = div_zero_q;
      err_d      = err_q;
      iter_step  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StCalc;
               div_zero_d = 1'b0;
               err_d      = 1'b0;
            end
         end
         StCalc: begin
            state_d = StDone;
            if (!legal) begin
               err_d = 1'b1;
               res_d = '0;
            end else if (ctrl_q[OP_DIV] && (y_q == '0)) begin
               div_zero_d = 1'b1;
               res_d      = '0;
            end else if (ctrl_q[OP_MUL] || ctrl_q[OP_DIV]) begin
               iter_step = 1'b1;
               if (iter_ready) begin
                  res_d = iter_result;
               end else begin
                  state_d = StCalc;
               end
            end else begin
               res_d = {{BITS{1'b0}}, simple_res};
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q    <= StIdle;
         x_q        <= '0;
         y_q        <= '0;
         ctrl_q     <= '0;
         res_q      <= '0;
         div_zero_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         res_q      <= res_d;
         div_zero_q <= div_zero_d;
         err_q      <= err_d;
         if (accept) begin
            x_q    <= X;
            y_q    <= Y;
            ctrl_q <= ctrl_signal;
         end
      end
   end

   assign busy     = (state_q == StCalc);
   assign done     = (state_q == StDone);
   assign OpResult = res_q;
   assign div_zero = div_zero_q;
   assign err      = err_q;

endmodule

// File: tb/tb_seq_alu.sv
`timescale 1ns/1ps
module tb_seq_alu;

   localparam int unsigned BITS      = 32;
   localparam int unsigned SIG_COUNT = 12;
   localparam int unsigned W         = 2 * BITS;

   localparam logic [11:0] C_ADD = 12'h001, C_SUB = 12'h002, C_MUL = 12'h004;
   localparam logic [11:0] C_DIV = 12'h008, C_SHR = 12'h010, C_SHL = 12'h020;
   localparam logic [11:0] C_ROR = 12'h040, C_ROL = 12'h080, C_AND = 12'h100;
   localparam logic [11:0] C_OR  = 12'h200, C_NEG = 12'h400, C_NOT = 12'h800;

   logic                 clock = 1'b0;
   logic                 clear_n;
   logic                 start;
   logic [SIG_COUNT-1:0] ctrl_signal;
   logic [BITS-1:0]      X, Y;
   logic                 busy, done, div_zero, err;
   logic [W-1:0]         OpResult;

   typedef struct {
      logic [W-1:0] res;
      logic         dz;
      logic         er;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   seq_alu #(
      .BITS      (BITS),
      .SIG_COUNT (SIG_COUNT)
   ) dut (
      .clock       (clock),
      .clear_n     (clear_n),
      .start       (start),
      .ctrl_signal (ctrl_signal),
      .X           (X),
      .Y           (Y),
      .busy        (busy),
      .done        (done),
      .OpResult    (OpResult),
      .div_zero    (div_zero),
      .err         (err)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op, then wait (bounded) for done and score it against the queue.
   // poke > 0 raises a stray start pulse that many edges after the accept.
   task automatic run_op(input string tag, input logic [11:0] c,
                         input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                         input logic [W-1:0] res, input logic dz, input logic er,
                         input int lat, input int poke);
      exp_t e;
      exp_t got;
      int   n;
      bit   seen;
      e.res = res; e.dz = dz; e.er = er; e.lat = lat;
      sb.push_back(e);
      @(negedge clock);
      ctrl_signal = c; X = a; Y = b; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      // Scramble inputs: only the latched copies may matter now.
      X = $urandom; Y = $urandom; ctrl_signal = 12'($urandom);
      chk({tag, "_busy"}, W'(busy), W'(1));
      n = 0; seen = 1'b0;
      while (!seen && n < 200) begin
         if (poke > 0 && n == poke) begin
            ctrl_signal = C_ADD; start = 1'b1;
         end
         @(posedge clock);
         n++;
         @(negedge clock);
         start = 1'b0;
         if (done) seen = 1'b1;
      end
      chk({tag, "_done_seen"}, W'(seen), W'(1));
      got = sb.pop_front();
      chk({tag, "_latency"}, W'(n), W'(got.lat));
      chk({tag, "_result"}, OpResult, got.res);
      chk({tag, "_div_zero"}, W'(div_zero), W'(got.dz));
      chk({tag, "_err"}, W'(err), W'(got.er));
      chk({tag, "_busy_at_done"}, W'(busy), W'(0));
      @(negedge clock);
      chk({tag, "_done_pulse"}, W'(done), W'(0));
   endtask

   initial begin
      int dones;
      int accepts;
      logic prev_busy;

      clear_n = 1'b0; start = 1'b0; ctrl_signal = '0; X = '0; Y = '0;
      repeat (2) @(negedge clock);
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_done", W'(done), W'(0));
      chk("rst_result", OpResult, W'(0));
      chk("rst_div_zero", W'(div_zero), W'(0));
      chk("rst_err", W'(err), W'(0));
      clear_n = 1'b1;

      // Simple ops sweep, X=15 Y=5.
      run_op("add", C_ADD, 32'd15, 32'd5, 64'd20, 1'b0, 1'b0, 1, 0);
      run_op("sub", C_SUB, 32'd15, 32'd5, 64'd10, 1'b0, 1'b0, 1, 0);
      run_op("shr", C_SHR, 32'd15, 32'd5, 64'd0, 1'b0, 1'b0, 1, 0);
      run_op("shl", C_SHL, 32'd15, 32'd5, 64'd480, 1'b0, 1'b0, 1, 0);
      run_op("ror", C_ROR, 32'd15, 32'd5, 64'h0000_0000_7800_0000, 1'b0, 1'b0, 1, 0);
      run_op("rol", C_ROL, 32'd15, 32'd5, 64'd480, 1'b0, 1'b0, 1, 0);
      run_op("and", C_AND, 32'd15, 32'd5, 64'd5, 1'b0, 1'b0, 1, 0);
      run_op("or",  C_OR,  32'd15, 32'd5, 64'd15, 1'b0, 1'b0, 1, 0);
      run_op("neg", C_NEG, 32'd15, 32'd5, 64'h0000_0000_FFFF_FFF1, 1'b0, 1'b0, 1, 0);
      run_op("not", C_NOT, 32'd15, 32'd5, 64'h0000_0000_FFFF_FFF0, 1'b0, 1'b0, 1, 0);
      run_op("add_wrap", C_ADD, 32'hFFFF_FFFF, 32'd2, 64'd1, 1'b0, 1'b0, 1, 0);

      // Multiply signs.
      run_op("mul_pp", C_MUL, 32'd15, 32'd5, 64'd75, 1'b0, 1'b0, 32, 0);
      run_op("mul_np", C_MUL, -32'sd15, 32'd5, 64'hFFFF_FFFF_FFFF_FFB5, 1'b0, 1'b0, 32, 0);
      run_op("mul_pn", C_MUL, 32'd15, -32'sd5, 64'hFFFF_FFFF_FFFF_FFB5, 1'b0, 1'b0, 32, 0);
      run_op("mul_nn", C_MUL, -32'sd15, -32'sd5, 64'd75, 1'b0, 1'b0, 32, 0);
      run_op("mul_min", C_MUL, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000,
             1'b0, 1'b0, 32, 0);

      // Divide signs: {remainder, quotient}.
      run_op("div_pp", C_DIV, 32'd15, 32'd5, 64'h0000_0000_0000_0003, 1'b0, 1'b0, 33, 0);
      run_op("div_np", C_DIV, -32'sd15, 32'd4, 64'hFFFF_FFFD_FFFF_FFFD, 1'b0, 1'b0, 33, 0);
      run_op("div_pn", C_DIV, 32'd15, -32'sd4, 64'h0000_0003_FFFF_FFFD, 1'b0, 1'b0, 33, 0);
      run_op("div_min", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000,
             1'b0, 1'b0, 33, 0);

      // Divide by zero, illegal controls, then flags clear on a valid accept.
      run_op("div_zero", C_DIV, 32'd15, 32'd0, 64'd0, 1'b1, 1'b0, 1, 0);
      run_op("ctrl_multi", 12'h003, 32'd15, 32'd5, 64'd0, 1'b0, 1'b1, 1, 0);
      run_op("ctrl_none", 12'h000, 32'd15, 32'd5, 64'd0, 1'b0, 1'b1, 1, 0);
      run_op("flags_clear", C_ADD, 32'd1, 32'd1, 64'd2, 1'b0, 1'b0, 1, 0);

      // Reset in the middle of a multiply.
      begin
         exp_t e;
         e.res = 64'd75; e.dz = 1'b0; e.er = 1'b0; e.lat = 32;
         sb.push_back(e);
      end
      @(negedge clock);
      ctrl_signal = C_MUL; X = 32'd15; Y = 32'd5; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (9) @(negedge clock);
      clear_n = 1'b0;
      #1;
      sb.delete();
      chk("abort_busy", W'(busy), W'(0));
      chk("abort_done", W'(done), W'(0));
      chk("abort_result", OpResult, W'(0));
      chk("abort_flags", W'({div_zero, err}), W'(0));
      @(negedge clock);
      clear_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (done) dones++;
      end
      chk("abort_no_done", W'(dones), W'(0));
      run_op("after_abort", C_ADD, 32'd3, 32'd5, 64'd8, 1'b0, 1'b0, 1, 0);

      // Stray start while busy is ignored and yields no extra done.
      run_op("mul_poke", C_MUL, 32'd15, 32'd5, 64'd75, 1'b0, 1'b0, 32, 5);
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (done) dones++;
      end
      chk("poke_no_extra_done", W'(dones), W'(0));

      // Start held high for 70 edges: accepts at edges 0, 34, 68 -> three ops.
      @(negedge clock);
      ctrl_signal = C_MUL; X = 32'd15; Y = 32'd5; start = 1'b1;
      dones = 0; accepts = 0; prev_busy = busy;
      for (int i = 0; i < 120; i++) begin
         @(posedge clock);
         @(negedge clock);
         if (i == 69) start = 1'b0;
         if (busy && !prev_busy) accepts++;
         prev_busy = busy;
         if (done) begin
            dones++;
            chk("held_result", OpResult, 64'd75);
         end
      end
      chk("held_accepts", W'(accepts), W'(3));
      chk("held_dones", W'(dones), W'(3));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
